// File: rtl/cnn_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_stream_pkg
// Brief    : Shared widths, class encodings and streamer state type.
// Revision : 1.0
// ============================================================================
package cnn_stream_pkg;

    localparam int DATA_W      = 32;
    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = 4;

    localparam logic [CLASS_W-1:0] CLASS_ERR = 4'd15;

    typedef enum logic [2:0] {
        LOAD,
        IDLE,
        STREAM,
        GAP,
        WAIT_RES,
        HOLD_RES
    } streamer_state_t;

endpackage : cnn_stream_pkg
`default_nettype wire

// File: rtl/cnn_frame_streamer_onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decoder
// Brief    : Maps a one-hot classification vector to its class index.
// Revision : 1.0
// ============================================================================
module onehot_decoder
    import cnn_stream_pkg::*;
(
    input  logic [NUM_CLASSES-1:0] i_onehot,
    output logic [CLASS_W-1:0]     o_class,
    output logic                   o_valid
);

    logic [CLASS_W-1:0] w_idx;
    logic [CLASS_W-1:0] w_ones;

    // o_valid only when exactly one bit is set; anything else reports CLASS_ERR
    always_comb begin
        w_idx  = '0;
        w_ones = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (i_onehot[i]) begin
                w_ones = w_ones + CLASS_W'(1);
                w_idx  = CLASS_W'(i);
            end
        end
        o_valid = (w_ones == CLASS_W'(1));
        o_class = o_valid ? w_idx : CLASS_ERR;
    end

endmodule : onehot_decoder
`default_nettype wire

// File: rtl/cnn_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_frame_streamer
// Brief    : Feeds host frame words into the CNN pipeline and returns the result.
// Revision : 1.0
// ============================================================================
module cnn_frame_streamer
    import cnn_stream_pkg::*;
#(
    parameter int unsigned FRAME_WORDS    = 1024,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    output logic                   load,
    input  logic                   load_weight_done,
    output logic                   input_valid,
    output logic                   sof,
    output logic [DATA_W-1:0]      d_in,
    input  logic                   output_valid,
    input  logic [NUM_CLASSES-1:0] d_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CLASS_W-1:0]     res_class,
    output logic                   res_err,
    output logic                   busy
);

    localparam int unsigned CNT_W = 17;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] c_frame_words = CNT_W'(FRAME_WORDS);
    localparam logic [GAP_W-1:0] c_gap_last    = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  c_to_last     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic             c_has_gap     = (GAP_CYCLES != 0);

    streamer_state_t    r_state, w_state;
    logic               r_load, w_load;
    logic [DATA_W-1:0]  r_d_in, w_d_in;
    logic               r_input_valid, w_input_valid;
    logic               r_sof, w_sof;
    logic               r_res_valid, w_res_valid;
    logic [CLASS_W-1:0] r_res_class, w_res_class;
    logic               r_res_err, w_res_err;
    logic               r_busy, w_busy;
    logic [CNT_W-1:0]   r_word_cnt, w_word_cnt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt;
    logic [TO_W-1:0]    r_to_cnt, w_to_cnt;
    logic               w_s_ready;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CLASS_W-1:0] w_dec_class;
    logic               w_dec_valid;

    onehot_decoder u_decoder (
        .i_onehot (d_out),
        .o_class  (w_dec_class),
        .o_valid  (w_dec_valid)
    );

    assign w_cnt_inc = r_word_cnt + CNT_W'(1);

    always_comb begin
        w_state       = r_state;
        w_load        = r_load;
        w_d_in        = r_d_in;
        w_input_valid = 1'b0;
        w_sof         = 1'b0;
        w_res_valid   = r_res_valid;
        w_res_class   = r_res_class;
        w_res_err     = r_res_err;
        w_word_cnt    = r_word_cnt;
        w_gap_cnt     = r_gap_cnt;
        w_to_cnt      = r_to_cnt;
        w_s_ready     = 1'b0;

        case (r_state)
            LOAD: begin
                if (load_weight_done) begin
                    w_load  = 1'b0;
                    w_state = IDLE;
                end
            end

            IDLE: begin
                w_s_ready = 1'b1;
                if (s_valid) begin
                    w_d_in        = s_data;
                    w_input_valid = 1'b1;
                    w_sof         = 1'b1;
                    w_word_cnt    = CNT_W'(1);
                    w_gap_cnt     = '0;
                    w_state       = c_has_gap ? GAP : STREAM;
                end
            end

            STREAM: begin
                w_s_ready = (r_word_cnt < c_frame_words);
                if (w_s_ready && s_valid) begin
                    w_d_in        = s_data;
                    w_input_valid = 1'b1;
                    w_word_cnt    = w_cnt_inc;
                    if (w_cnt_inc == c_frame_words) begin
                        w_to_cnt = '0;
                        w_state  = WAIT_RES;
                    end else if (c_has_gap) begin
                        w_gap_cnt = '0;
                        w_state   = GAP;
                    end
                end
            end

            // Pipeline has no backpressure, so the gap is a hard minimum spacing
            GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_gap_cnt = '0;
                    w_state   = STREAM;
                end else begin
                    w_gap_cnt = r_gap_cnt + GAP_W'(1);
                end
            end

            // A real result on the timeout cycle takes priority over the timeout
            WAIT_RES: begin
                w_to_cnt = r_to_cnt + TO_W'(1);
                if (output_valid) begin
                    w_res_valid = 1'b1;
                    w_res_class = w_dec_class;
                    w_res_err   = ~w_dec_valid;
                    w_state     = HOLD_RES;
                end else if (r_to_cnt == c_to_last) begin
                    w_res_valid = 1'b1;
                    w_res_class = CLASS_ERR;
                    w_res_err   = 1'b1;
                    w_state     = HOLD_RES;
                end
            end

            HOLD_RES: begin
                if (res_ready) begin
                    w_res_valid = 1'b0;
                    w_state     = IDLE;
                end
            end

            default: w_state = LOAD;
        endcase

        // Registered from next state so busy reads 0 while rst is held
        w_busy = (w_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= LOAD;
            r_load        <= 1'b1;
            r_d_in        <= '0;
            r_input_valid <= 1'b0;
            r_sof         <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_class   <= '0;
            r_res_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_word_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_state       <= w_state;
            r_load        <= w_load;
            r_d_in        <= w_d_in;
            r_input_valid <= w_input_valid;
            r_sof         <= w_sof;
            r_res_valid   <= w_res_valid;
            r_res_class   <= w_res_class;
            r_res_err     <= w_res_err;
            r_busy        <= w_busy;
            r_word_cnt    <= w_word_cnt;
            r_gap_cnt     <= w_gap_cnt;
            r_to_cnt      <= w_to_cnt;
        end
    end

    assign s_ready     = w_s_ready;
    assign load        = r_load;
    assign d_in        = r_d_in;
    assign input_valid = r_input_valid;
    assign sof         = r_sof;
    assign res_valid   = r_res_valid;
    assign res_class   = r_res_class;
    assign res_err     = r_res_err;
    assign busy        = r_busy;

endmodule : cnn_frame_streamer
`default_nettype wire

// File: tb/tb_cnn_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_frame_streamer
// Brief    : Directed self-checking bench with word and result scoreboards.
// Revision : 1.0
// ============================================================================
module tb_cnn_frame_streamer;

    localparam int FW = 4;
    localparam int GP = 2;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        load_weight_done = 1'b0;
    logic        output_valid = 1'b0;
    logic [9:0]  d_out = '0;
    logic        res_ready = 1'b0;
    logic        s_ready, load, input_valid, sof, res_valid, res_err, busy;
    logic [31:0] d_in;
    logic [3:0]  res_class;

    logic        s_valid0 = 1'b0;
    logic [31:0] s_data0 = '0;
    logic        s_ready0, load0, input_valid0, sof0, res_valid0, res_err0, busy0;
    logic [31:0] d_in0;
    logic [3:0]  res_class0;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [32:0] exp_q[$];
    logic [4:0]  res_q[$];
    int          pulse_q[$];
    logic [32:0] mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cnn_frame_streamer #(.FRAME_WORDS(FW), .GAP_CYCLES(GP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .load(load), .load_weight_done(load_weight_done), .input_valid(input_valid),
        .sof(sof), .d_in(d_in), .output_valid(output_valid), .d_out(d_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
        .res_err(res_err), .busy(busy)
    );

    cnn_frame_streamer #(.FRAME_WORDS(FW), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
        .load(load0), .load_weight_done(load_weight_done), .input_valid(input_valid0),
        .sof(sof0), .d_in(d_in0), .output_valid(1'b0), .d_out(10'd0),
        .res_valid(res_valid0), .res_ready(1'b0), .res_class(res_class0),
        .res_err(res_err0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word scoreboard: every input_valid pops one expected {sof, data}
    always @(negedge clk) begin
        if (!rst && input_valid) begin
            pulse_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_word_qsize", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("d_in", 64'(d_in), 64'(mon_e[31:0]));
                chk("sof", 64'(sof), 64'(mon_e[32]));
            end
        end else if (!rst) begin
            chk("sof_without_valid", 64'(sof), 64'd0);
        end
    end

    task automatic send_word(input logic [31:0] d, input logic first);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 100) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            chk("s_ready_wait", 64'(s_ready), 64'd1);
            s_valid = 1'b0;
            return;
        end
        exp_q.push_back({first, d});
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base);
        for (int i = 0; i < FW; i++) send_word(base + 32'(i), (i == 0));
    endtask

    task automatic drive_result(input logic [9:0] v);
        output_valid = 1'b1;
        d_out        = v;
        tick();
        output_valid = 1'b0;
        d_out        = '0;
    endtask

    task automatic get_result(input int hold);
        int n = 0;
        logic [4:0] e;
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        chk("res_valid_seen", 64'(res_valid), 64'd1);
        if (res_q.size() == 0) begin
            chk("result_qsize", 64'(res_q.size()), 64'd1);
            return;
        end
        e = res_q.pop_front();
        chk("res_class", 64'(res_class), 64'(e[3:0]));
        chk("res_err", 64'(res_err), 64'(e[4]));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("res_valid_hold", 64'(res_valid), 64'd1);
            chk("res_class_hold", 64'(res_class), 64'(e[3:0]));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_clear", 64'(res_valid), 64'd0);
        chk("busy_after_res", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_load", 64'(load), 64'd1);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_input_valid", 64'(input_valid), 64'd0);
        chk("rst_sof", 64'(sof), 64'd0);
        chk("rst_d_in", 64'(d_in), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_class", 64'(res_class), 64'd0);
        chk("rst_res_err", 64'(res_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Weight load
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("load_held", 64'(load), 64'd1);
            chk("load_s_ready", 64'(s_ready), 64'd0);
        end
        chk("load_busy", 64'(busy), 64'd1);
        load_weight_done = 1'b1;
        tick();
        load_weight_done = 1'b0;
        chk("load_dropped", 64'(load), 64'd0);
        chk("idle_s_ready", 64'(s_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        // Frame with gaps
        pulse_q.delete();
        send_frame(32'hA0);
        chk("s_ready_after_last", 64'(s_ready), 64'd0);
        chk("busy_wait_res", 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        chk("pulse_count", 64'(pulse_q.size()), 64'd4);
        if (pulse_q.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("pulse_spacing", 64'(pulse_q[i] - pulse_q[i-1]), 64'(GP + 1));
        end

        // Good result, held while host stalls
        res_q.push_back({1'b0, 4'd5});
        drive_result(10'b0000100000);
        get_result(5);

        // Malformed results
        send_frame(32'hC0);
        res_q.push_back({1'b1, 4'd15});
        drive_result(10'b0000000000);
        get_result(0);
        send_frame(32'hD0);
        res_q.push_back({1'b1, 4'd15});
        drive_result(10'b1000000001);
        get_result(0);

        // Timeout, then a late output_valid that must be ignored
        send_frame(32'hE0);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("no_early_timeout", 64'(res_valid), 64'd0);
        end
        tick();
        chk("timeout_valid", 64'(res_valid), 64'd1);
        chk("timeout_class", 64'(res_class), 64'd15);
        chk("timeout_err", 64'(res_err), 64'd1);
        drive_result(10'b0000000001);
        chk("late_ov_valid", 64'(res_valid), 64'd1);
        chk("late_ov_class", 64'(res_class), 64'd15);
        chk("late_ov_err", 64'(res_err), 64'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("timeout_res_clear", 64'(res_valid), 64'd0);

        // Reset mid-frame
        send_word(32'hF0, 1'b1);
        send_word(32'hF1, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("midrst_load", 64'(load), 64'd1);
        chk("midrst_input_valid", 64'(input_valid), 64'd0);
        chk("midrst_sof", 64'(sof), 64'd0);
        chk("midrst_d_in", 64'(d_in), 64'd0);
        chk("midrst_s_ready", 64'(s_ready), 64'd0);
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_words_drained", 64'(exp_q.size()), 64'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("reload_load", 64'(load), 64'd1);
        load_weight_done = 1'b1;
        tick();
        load_weight_done = 1'b0;
        chk("reload_done", 64'(load), 64'd0);

        // Fresh frame starts with sof
        send_frame(32'h60);
        res_q.push_back({1'b0, 4'd9});
        drive_result(10'b1000000000);
        get_result(2);

        // GAP_CYCLES=0 instance: consecutive strobes
        s_valid0 = 1'b1;
        s_data0  = 32'hB0;
        chk("nogap_s_ready", 64'(s_ready0), 64'd1);
        for (int i = 0; i < FW; i++) begin
            tick();
            chk("nogap_input_valid", 64'(input_valid0), 64'd1);
            chk("nogap_d_in", 64'(d_in0), 64'(32'hB0 + 32'(i)));
            chk("nogap_sof", 64'(sof0), 64'(i == 0));
            s_data0 = 32'hB0 + 32'(i + 1);
        end
        s_valid0 = 1'b0;
        chk("nogap_s_ready_end", 64'(s_ready0), 64'd0);
        tick();
        chk("nogap_idle_strobe", 64'(input_valid0), 64'd0);

        chk("words_all_seen", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_cnn_frame_streamer
`default_nettype wire

// File: doc/cnn_frame_streamer.md
Name: cnn_frame_streamer

Overview:
- Host-side driver and harvester for the CNN inference pipeline.
- Accepts 32-bit frame words from the host over a valid/ready port.
- Drives the pipeline's load / input_valid / sof / d_in stream; the pipeline has no backpressure, so the block inserts a fixed gap between words.
- Captures the pipeline's 10-bit one-hot classification, decodes it to a class index, and holds it for the host on a valid/ready result port.

Parameters:
- FRAME_WORDS, 1024: words per frame sent to the pipeline (legal range 2..65535).
- GAP_CYCLES, 0: idle cycles forced between consecutive input_valid pulses.
- TIMEOUT_CYCLES, 1000000: cycles waited in WAIT_RES before a timeout result is produced.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  host word valid
- s_ready  out  1  host word accepted when s_valid & s_ready
- s_data  in  32  host frame word
- load  out  1  weight-load request to pipeline
- load_weight_done  in  1  pipeline weight load complete
- input_valid  out  1  pipeline word strobe
- sof  out  1  first word of frame, coincident with input_valid
- d_in  out  32  pipeline data word
- output_valid  in  1  pipeline result strobe
- d_out  in  10  pipeline one-hot result
- res_valid  out  1  result available
- res_ready  in  1  host consumes result
- res_class  out  4  decoded class 0..9; 15 on error
- res_err  out  1  d_out not exactly one-hot, or timeout
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0 except load=1; state LOAD; word counter 0; gap counter 0; timeout counter 0.
- Clock and reset: single clock; rst is synchronous, active-high, and overrides everything. Reset mid-frame abandons the frame; no partial sof is emitted afterwards.
- States are LOAD, IDLE, STREAM, GAP, WAIT_RES, HOLD_RES.
- LOAD: load=1, s_ready=0. On load_weight_done=1: load<=0, go to IDLE next cycle. load_weight_done is sampled only in LOAD.
- IDLE: s_ready=1. On s_valid (handshake): register s_data to d_in, pulse input_valid=1 and sof=1 for one cycle, set word counter to 1, go to STREAM (GAP_CYCLES=0) or GAP (GAP_CYCLES>0).
- STREAM:
  - s_ready=1 while counter<FRAME_WORDS.
  - Each handshake emits a registered word with sof=0; input_valid follows the handshake by 1 cycle.
  - The word that makes counter==FRAME_WORDS goes to WAIT_RES; otherwise go to GAP if GAP_CYCLES>0.
  - s_ready drops combinationally once the last word is accepted.
- GAP: s_ready=0, input_valid=0 for exactly GAP_CYCLES cycles, then back to STREAM. Host throttling (s_valid=0) only lengthens gaps and never corrupts the count.
- Throughput: maximum is one word per (1+GAP_CYCLES) cycles.
- WAIT_RES:
  - s_ready=0; timeout counter increments every cycle.
  - On output_valid: decode d_out, load res_class/res_err, set res_valid=1, go to HOLD_RES.
  - Decode: exactly one bit set at position k gives res_class=k, res_err=0; zero or more than one bit set gives res_class=15, res_err=1.
  - When the counter reaches TIMEOUT_CYCLES-1 without output_valid: res_class=15, res_err=1, res_valid=1, go to HOLD_RES.
  - If output_valid arrives on the timeout cycle, output_valid wins.
- HOLD_RES: res_valid, res_class and res_err stay stable until res_ready. On res_valid & res_ready: clear res_valid, go to IDLE.
- Results are not queued. output_valid arriving outside WAIT_RES is ignored and sets no flag.
- Host words arriving outside IDLE/STREAM wait via s_ready=0; none are dropped.

Decomposition:
- Package cnn_stream_pkg holds:
  - DATA_W=32, NUM_CLASSES=10, CLASS_W=4, CLASS_ERR=4'd15;
  - typedef enum logic [2:0] streamer_state_t {LOAD, IDLE, STREAM, GAP, WAIT_RES, HOLD_RES}.
- One sub-module, onehot_decoder: combinational, 10-bit in, outputs class index plus a valid flag (exactly one bit set). Everything else lives in cnn_frame_streamer.

Test Plan (FRAME_WORDS=4, GAP_CYCLES=2, TIMEOUT_CYCLES=50 unless stated):
- Load: release rst, hold load_weight_done=0 for 10 cycles, then 1 -> load stays 1 through those 10 cycles and drops 1 cycle after done; s_ready=0 until IDLE.
- Frame stream: host streams 0xA0,0xA1,0xA2,0xA3 back-to-back.
  - d_in follows that sequence; input_valid pulses are 3 cycles apart.
  - sof=1 only with 0xA0; exactly 4 pulses; s_ready=0 after 0xA3.
- Good result: output_valid with d_out=10'b0000100000 -> res_class=5, res_err=0, res_valid held across 5 cycles of res_ready=0, cleared the cycle after res_ready=1; busy=0 afterwards.
- Bad result: d_out=10'b0000000000 gives res_class=15, res_err=1; a second frame with d_out=10'b1000000001 gives res_class=15, res_err=1.
- Timeout: no output_valid for 50 cycles after the last word -> res_valid with res_class=15, res_err=1 on cycle 50. A late output_valid during HOLD_RES is ignored.
- Reset mid-frame and back-to-back frames:
  - Assert rst after word 2 -> load=1, all other outputs 0, state LOAD.
  - Next frame after reload starts with sof=1.
  - With GAP_CYCLES=0, a frame of 4 words produces 4 consecutive input_valid cycles.
